instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch.sv | 96 +++++++++
 tb/tb_instr_dispatch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch.sv
// Group dispatch FIFO between issue and instr_commit: buffers IW-wide instruction
// groups and hands the head group to the ROB. Optional same-cycle bypass: DISPATCH_BYPASS_EN.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

package dispatch_pkg;
  typedef logic [3:0] rob_idx_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] opcode;
    rob_idx_t    rob_idx;
  } issued_instr_t;
endpackage

module instr_dispatch
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = `ISSUE_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  issued_instr_t [IW-1:0]    i_instrs,
  output logic                      o_ready,
  input  logic                      i_rob_avail,
  input  rob_idx_t [IW-1:0]         i_rob_idx,
  output logic                      o_enqueue,
  output issued_instr_t [IW-1:0]    o_instrs,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  issued_instr_t [IW-1:0] mem [DEPTH];
  issued_instr_t [IW-1:0] head;

  logic empty;
  logic bypass;
  logic head_valid;
  logic push;
  logic pop;

  always_comb begin
    empty = (count == '0);
`ifdef DISPATCH_BYPASS_EN
    // An empty FIFO with a ready ROB hands the incoming group straight through.
    bypass = empty & i_valid & i_rob_avail & ~i_flush;
`else
    bypass = 1'b0;
`endif
    // Ready looks only at registered occupancy, so a pop cannot free a slot early.
    o_ready    = (count < CW'(DEPTH)) & ~i_flush;
    push       = i_valid & o_ready & ~bypass;
    head_valid = ~empty | bypass;
    o_enqueue  = head_valid & i_rob_avail & ~i_flush;
    pop        = o_enqueue & ~bypass;
    head       = bypass ? i_instrs : mem[rd_ptr];
    o_instrs   = head;
    for (int k = 0; k < IW; k++) begin
      o_instrs[k].rob_idx = i_rob_idx[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_instrs;
  end

  assign o_count = count;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed table plus hand sequences and a queue-model random run for instr_dispatch.
module tb_instr_dispatch;

  localparam int IW    = 2;
  localparam int DEPTH = 4;
  localparam int SW    = 21;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_flush = 1'b0;
  logic              i_valid = 1'b0;
  logic [IW*SW-1:0]  i_instrs = '0;
  logic              o_ready;
  logic              i_rob_avail = 1'b0;
  logic [IW*4-1:0]   i_rob_idx = '0;
  logic              o_enqueue;
  logic [IW*SW-1:0]  o_instrs;
  logic [2:0]        o_count;

  int checks = 0;
  int failures = 0;
  logic [3:0] rob_base = 4'd0;

  instr_dispatch #(.DEPTH(DEPTH), .IW(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_instrs(i_instrs), .o_ready(o_ready), .i_rob_avail(i_rob_avail),
    .i_rob_idx(i_rob_idx), .o_enqueue(o_enqueue), .o_instrs(o_instrs),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          v;
    bit          av;
    bit          fl;
    logic [11:0] op;
    bit          enq;
    logic [11:0] eop;
    int          cnt;
    bit          rdy;
  } vec_t;

  vec_t tbl[$];

  // Slot k: {valid, opcode = {op, k}, rob_idx}; inputs carry rob_idx 4'hF so replacement is visible.
  function automatic logic [IW*SW-1:0] mk(input logic [11:0] op, input logic [3:0] base, input bit fixed);
    logic [IW*SW-1:0] g;
    g = '0;
    for (int k = 0; k < IW; k++) begin
      logic [3:0] r;
      r = fixed ? 4'hF : base + 4'(k);
      g[k*SW +: SW] = {1'b1, op, 4'(k), r};
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit av, input bit fl, input logic [11:0] op);
    i_valid     = v;
    i_rob_avail = av;
    i_flush     = fl;
    i_instrs    = mk(op, 4'd0, 1'b1);
    rob_base    = rob_base + 4'd3;
    for (int k = 0; k < IW; k++) i_rob_idx[k*4 +: 4] = rob_base + 4'(k);
  endtask

  task automatic step(input string tag, input bit v, input bit av, input bit fl, input logic [11:0] op,
                      input bit enq, input logic [11:0] eop, input int cnt, input bit rdy);
    @(negedge i_clk);
    drive(v, av, fl, op);
    #1;
    chk({tag, ".count"}, 64'(o_count), 64'(cnt));
    chk({tag, ".ready"}, 64'(o_ready), 64'(rdy));
    chk({tag, ".enqueue"}, 64'(o_enqueue), 64'(enq));
    if (enq) chk({tag, ".instrs"}, 64'(o_instrs), 64'(mk(eop, rob_base, 1'b0)));
  endtask

  task automatic add(input bit v, input bit av, input bit fl, input logic [11:0] op,
                     input bit enq, input logic [11:0] eop, input int cnt, input bit rdy);
    tbl.push_back('{v, av, fl, op, enq, eop, cnt, rdy});
  endtask

  logic [11:0] q[$];

  initial begin
    // Fill A,B,C with ROB stalled, then drain in order.
    add(1,0,0,12'd1, 0,0,0,1);
    add(1,0,0,12'd2, 0,0,1,1);
    add(1,0,0,12'd3, 0,0,2,1);
    add(0,0,0,0,     0,0,3,1);
    add(0,1,0,0,     1,12'd1,3,1);
    add(0,1,0,0,     1,12'd2,2,1);
    add(0,1,0,0,     1,12'd3,1,1);
    add(0,1,0,0,     0,0,0,1);
    // Fill to DEPTH, fifth group ignored, pop while full does not accept.
    add(1,0,0,12'd4, 0,0,0,1);
    add(1,0,0,12'd5, 0,0,1,1);
    add(1,0,0,12'd6, 0,0,2,1);
    add(1,0,0,12'd7, 0,0,3,1);
    add(1,0,0,12'd8, 0,0,4,0);
    add(1,1,0,12'd9, 1,12'd4,4,0);
    // Simultaneous push and pop across pointer wraps.
    add(1,1,0,12'd10, 1,12'd5,3,1);
    add(1,1,0,12'd11, 1,12'd6,3,1);
    add(1,1,0,12'd12, 1,12'd7,3,1);
    add(1,1,0,12'd13, 1,12'd10,3,1);
    add(1,1,0,12'd14, 1,12'd11,3,1);
    add(1,1,0,12'd15, 1,12'd12,3,1);
    add(1,1,0,12'd16, 1,12'd13,3,1);
    add(1,1,0,12'd17, 1,12'd14,3,1);
    add(0,1,0,0,      1,12'd15,3,1);
    add(0,1,0,0,      1,12'd16,2,1);
    add(0,1,0,0,      1,12'd17,1,1);
    add(0,0,0,0,      0,0,0,1);
    // Flush with count=3 beats push and pop.
    add(1,0,0,12'd20, 0,0,0,1);
    add(1,0,0,12'd21, 0,0,1,1);
    add(1,0,0,12'd22, 0,0,2,1);
    add(1,1,1,12'd23, 0,0,3,0);
    add(0,1,0,0,      0,0,0,1);
    add(1,0,0,12'd24, 0,0,0,1);
    add(0,1,0,0,      1,12'd24,1,1);
    add(0,0,0,0,      0,0,0,1);

    #3;
    chk("reset.count", 64'(o_count), 64'd0);
    chk("reset.ready", 64'(o_ready), 64'd1);
    chk("reset.enqueue", 64'(o_enqueue), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].av, tbl[i].fl, tbl[i].op,
           tbl[i].enq, tbl[i].eop, tbl[i].cnt, tbl[i].rdy);
    end

    // Asynchronous reset with two groups buffered.
    step("rst.fill0", 1,0,0,12'd30, 0,0,0,1);
    step("rst.fill1", 1,0,0,12'd31, 0,0,1,1);
    @(negedge i_clk);
    drive(0, 1, 0, 12'd0);
    #1;
    chk("rst.pre_count", 64'(o_count), 64'd2);
    i_rst = 1'b1;
    #1;
    chk("rst.count", 64'(o_count), 64'd0);
    chk("rst.enqueue", 64'(o_enqueue), 64'd0);
    chk("rst.ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    step("rst.push_x", 1,0,0,12'd40, 0,0,0,1);
    step("rst.enq_x",  0,1,0,0,      1,12'd40,1,1);
    step("rst.empty",  0,0,0,0,      0,0,0,1);

    // Empty FIFO with valid input and ready ROB.
`ifdef DISPATCH_BYPASS_EN
    step("byp.same", 1,1,0,12'd50, 1,12'd50,0,1);
    step("byp.after", 0,0,0,0,     0,0,0,1);
`else
    step("byp.same", 1,1,0,12'd50, 0,0,0,1);
    step("byp.next", 0,1,0,0,      1,12'd50,1,1);
    step("byp.after", 0,0,0,0,     0,0,0,1);
`endif

    // Random traffic against a queue model.
    for (int c = 0; c < 10000; c++) begin
      bit v, av, fl, rdy, byp, enq;
      logic [11:0] op;
      @(negedge i_clk);
      v  = ($urandom_range(0, 9) < 7);
      av = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 39) == 0);
      op = 12'($urandom);
      drive(v, av, fl, op);
      #1;
      rdy = (q.size() < DEPTH) && !fl;
`ifdef DISPATCH_BYPASS_EN
      byp = (q.size() == 0) && v && av && !fl;
`else
      byp = 1'b0;
`endif
      enq = ((q.size() > 0) || byp) && av && !fl;
      chk("rand.count", 64'(o_count), 64'(q.size()));
      chk("rand.ready", 64'(o_ready), 64'(rdy));
      chk("rand.enqueue", 64'(o_enqueue), 64'(enq));
      if (enq) chk("rand.instrs", 64'(o_instrs), 64'(mk(byp ? op : q[0], rob_base, 1'b0)));
      if (fl) begin
        q.delete();
      end else begin
        if (enq && !byp) void'(q.pop_front());
        if (v && rdy && !byp) q.push_back(op);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
